// File: rtl/bus_op_pipe.sv
// One-stage valid/ready ALU pipe with a running accumulator and registered flags.
// Define BUS_OP_PIPE_SAT_EN to saturate ADD/ACC/SUB results; flags stay unsaturated.
module bus_op_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_ACC = 3'd5;
    localparam logic [2:0] OP_CLR = 3'd6;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_overflow;
    logic [WIDTH-1:0] r_acc;

    logic             w_in_xfer;
    logic [WIDTH-1:0] w_add_x;
    logic [WIDTH-1:0] w_add_y;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_in_xfer = in_valid && in_ready;

    // ACC reuses the adder with the accumulator in place of operand A.
    assign w_add_x   = (op == OP_ACC) ? r_acc  : data_a;
    assign w_add_y   = (op == OP_ACC) ? data_a : data_b;
    assign w_sum     = {1'b0, w_add_x} + {1'b0, w_add_y};
    assign w_diff    = {1'b0, data_a} - {1'b0, data_b};
    assign w_add_ovf = (w_add_x[WIDTH-1] == w_add_y[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != w_add_x[WIDTH-1]);
    assign w_sub_ovf = (data_a[WIDTH-1] != data_b[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != data_a[WIDTH-1]);

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (op)
            OP_AND: w_res = data_a & data_b;
            OP_OR:  w_res = data_a | data_b;
            OP_XOR: w_res = data_a ^ data_b;
            OP_ADD, OP_ACC: begin
                w_carry = w_sum[WIDTH];
                w_ovf   = w_add_ovf;
`ifdef BUS_OP_PIPE_SAT_EN
                w_res   = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
                w_res   = w_sum[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                w_carry = w_diff[WIDTH];
                w_ovf   = w_sub_ovf;
`ifdef BUS_OP_PIPE_SAT_EN
                w_res   = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
`else
                w_res   = w_diff[WIDTH-1:0];
`endif
            end
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_acc       <= '0;
        end else begin
            if (w_in_xfer) begin
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_carry     <= w_carry;
                r_overflow  <= w_ovf;
                if (op == OP_ACC)
                    r_acc <= w_res;
                else if (op == OP_CLR)
                    r_acc <= '0;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign zero      = (r_result == '0);

endmodule

// File: tb/tb_bus_op_pipe.sv
// Directed self-checking bench for bus_op_pipe at WIDTH=8.
// Expected values are hand-computed; saturating variants selected by BUS_OP_PIPE_SAT_EN.
module tb_bus_op_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       overflow;
    logic       zero;

    int checks   = 0;
    int failures = 0;

    bus_op_pipe #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .data_a   (data_a),
        .data_b   (data_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] r,
                           input logic c, input logic o, input logic z);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".result"}, 64'(result), 64'(r));
        chk({tag, ".carry"}, 64'(carry), 64'(c));
        chk({tag, ".ovf"}, 64'(overflow), 64'(o));
        chk({tag, ".zero"}, 64'(zero), 64'(z));
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic ordy);
        in_valid  = v;
        op        = o;
        data_a    = a;
        data_b    = b;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        #12;
        chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle.valid", 64'(out_valid), 64'd0);

        drive(1'b1, 3'd0, 8'hF0, 8'h3C, 1'b1); tick();
        chk_out("and", 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
`ifdef BUS_OP_PIPE_SAT_EN
        drive(1'b1, 3'd3, 8'hFF, 8'h01, 1'b1); tick();
        chk_out("add_ff_01", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
`else
        drive(1'b1, 3'd3, 8'hFF, 8'h01, 1'b1); tick();
        chk_out("add_ff_01", 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
`endif
        drive(1'b1, 3'd3, 8'h7F, 8'h01, 1'b1); tick();
        chk_out("add_7f_01", 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
`ifdef BUS_OP_PIPE_SAT_EN
        drive(1'b1, 3'd4, 8'h00, 8'h01, 1'b1); tick();
        chk_out("sub_00_01", 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
`else
        drive(1'b1, 3'd4, 8'h00, 8'h01, 1'b1); tick();
        chk_out("sub_00_01", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
`endif
        drive(1'b1, 3'd4, 8'h80, 8'h01, 1'b1); tick();
        chk_out("sub_80_01", 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 3'd1, 8'h0F, 8'hA0, 1'b1); tick();
        chk_out("or", 1'b1, 8'hAF, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd2, 8'hFF, 8'h0F, 1'b1); tick();
        chk_out("xor", 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd7, 8'hFF, 8'hFF, 1'b1); tick();
        chk_out("reserved", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

        drive(1'b1, 3'd6, 8'h55, 8'h66, 1'b1); tick();
        chk_out("clr", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr.acc", 64'(dut.r_acc), 64'h00);
        drive(1'b1, 3'd5, 8'h10, 8'hEE, 1'b1); tick();
        chk_out("acc1", 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd5, 8'h20, 8'hEE, 1'b1); tick();
        chk_out("acc2", 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd5, 8'h05, 8'hEE, 1'b1); tick();
        chk_out("acc3", 1'b1, 8'h35, 1'b0, 1'b0, 1'b0);
        chk("acc3.acc", 64'(dut.r_acc), 64'h35);

        // Reserved op and invalid input must leave the accumulator alone.
        drive(1'b1, 3'd7, 8'h12, 8'h34, 1'b1); tick();
        drive(1'b0, 3'd5, 8'h40, 8'h00, 1'b1); tick();
        chk("drain.valid", 64'(out_valid), 64'd0);
        chk("noxfer.acc", 64'(dut.r_acc), 64'h35);

        drive(1'b1, 3'd3, 8'h01, 8'h02, 1'b1); tick();
        chk_out("stall_add", 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd5, 8'h01, 8'h00, 1'b0);
        #1;
        chk("stall.in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stall", 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
            chk("stall.in_ready_hold", 64'(in_ready), 64'd0);
            chk("stall.acc", 64'(dut.r_acc), 64'h35);
        end
        out_ready = 1'b1;
        #1;
        chk("release.in_ready", 64'(in_ready), 64'd1);
        tick();
        chk_out("release_acc", 1'b1, 8'h36, 1'b0, 1'b0, 1'b0);
        chk("release.acc", 64'(dut.r_acc), 64'h36);

        drive(1'b1, 3'd3, 8'h01, 8'h01, 1'b1); tick();
        chk_out("pre_reset", 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd5, 8'h09, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mid_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("mid_reset.acc", 64'(dut.r_acc), 64'h00);
        chk("mid_reset.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        rst_n = 1'b1;
        tick();
        chk("post_reset.valid", 64'(out_valid), 64'd0);

        drive(1'b1, 3'd5, 8'h07, 8'h00, 1'b1); tick();
        chk_out("acc_after_reset", 1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
`ifdef BUS_OP_PIPE_SAT_EN
        drive(1'b1, 3'd5, 8'hFF, 8'h00, 1'b1); tick();
        chk_out("acc_carry", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
`else
        drive(1'b1, 3'd5, 8'hFF, 8'h00, 1'b1); tick();
        chk_out("acc_carry", 1'b1, 8'h06, 1'b1, 1'b0, 1'b0);
`endif
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1); tick();
        chk("final.valid", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_op_pipe.md
BUS_OP_PIPE -- requirements
Module: bus_op_pipe

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits; legal range is 2..64.
REQ-002 clk  input  1  SHALL be the single clock; all state is updated on the rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 in_valid  input  1  SHALL indicate that the op, data_a and data_b inputs carry a transfer.
REQ-005 in_ready  output  1  SHALL indicate that the block accepts a transfer this cycle.
REQ-006 op  input  3  SHALL select the operation: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 ACC, 6 CLR, 7 reserved.
REQ-007 data_a  input  WIDTH  SHALL carry operand A.
REQ-008 data_b  input  WIDTH  SHALL carry operand B.
REQ-009 out_valid  output  1  SHALL indicate that result and the flags hold a completed operation.
REQ-010 out_ready  input  1  SHALL indicate that the consumer takes the output this cycle.
REQ-011 result  output  WIDTH  SHALL carry the registered operation result.
REQ-012 carry  output  1  SHALL carry the registered unsigned carry/borrow flag.
REQ-013 overflow  output  1  SHALL carry the registered two's-complement overflow flag.
REQ-014 zero  output  1  SHALL be 1 when the registered result is 0.

Function
REQ-015 An input transfer SHALL occur on a clock edge where in_valid=1 and in_ready=1; an output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-016 in_ready SHALL be !out_valid || out_ready, so throughput is one op per cycle with no bubble.
REQ-017 Latency SHALL be 1 cycle: the result of an accepted transfer appears on the next edge together with out_valid=1.
REQ-018 When out_valid=1 and out_ready=0, result, the flags and out_valid SHALL hold stable.
REQ-019 When an output transfer occurs with no input transfer, out_valid SHALL drop to 0; when both occur on the same edge, the output SHALL be replaced by the new result and out_valid SHALL stay 1.
REQ-020 The logical ops AND, OR and XOR SHALL be bitwise A op B, with carry=0 and overflow=0.
REQ-021 ADD SHALL compute A+B mod 2^WIDTH, with carry = bit WIDTH of the sum and overflow = signed overflow.
REQ-022 SUB SHALL compute A-B mod 2^WIDTH, with carry = borrow (A<B unsigned) and overflow = signed overflow.
REQ-023 A WIDTH-bit accumulator acc SHALL exist.
REQ-024 ACC SHALL compute acc+A, write the sum to acc and to result, and set flags as ADD; data_b SHALL be ignored.
REQ-025 CLR SHALL set acc=0 and result=0, with carry=0 and overflow=0.
REQ-026 The reserved op 7 SHALL produce result=0 with all flags 0, and acc SHALL be unchanged.
REQ-027 acc SHALL update only on an input transfer; a stalled or invalid input SHALL never modify acc.
REQ-028 For back-to-back ACC transfers, each SHALL use the acc value left by the previous ACC, with no forwarding hazard.
REQ-029 zero SHALL always be computed from the registered result, including reserved and CLR ops.

Reset
REQ-030 rst_n=0 SHALL immediately clear out_valid, result, carry, overflow and acc to 0, and set zero=1.
REQ-031 A transfer in flight when reset asserts SHALL be discarded.
REQ-032 in_ready SHALL be 1 during and after reset, per REQ-016.
REQ-033 Reset deassertion SHALL take effect without any glitch on out_valid.

Configuration
REQ-034 With macro BUS_OP_PIPE_SAT_EN defined, ADD and ACC SHALL saturate to all-ones when carry=1, and SUB SHALL saturate to 0 when borrow=1.
REQ-035 When BUS_OP_PIPE_SAT_EN is defined, the flags SHALL still report the unsaturated carry and overflow.
REQ-036 When BUS_OP_PIPE_SAT_EN is defined, zero SHALL reflect the saturated result.
REQ-037 Without BUS_OP_PIPE_SAT_EN, all arithmetic SHALL wrap modulo 2^WIDTH.

Verification
REQ-038 WIDTH=8, out_ready=1: AND 0xF0,0x3C -> next cycle result=0x30, carry=0, overflow=0, zero=0.
REQ-039 ADD 0xFF,0x01 -> result=0x00, carry=1, zero=1 (with BUS_OP_PIPE_SAT_EN: result=0xFF, zero=0); ADD 0x7F,0x01 -> result=0x80, overflow=1.
REQ-040 SUB 0x00,0x01 -> result=0xFF, carry=1, overflow=0; SUB 0x80,0x01 -> result=0x7F, overflow=1.
REQ-041 CLR, then ACC 0x10, ACC 0x20, ACC 0x05 back-to-back -> results 0x10, 0x30, 0x35 on consecutive cycles, acc=0x35.
REQ-042 Hold out_ready=0 for 3 cycles after ADD 1,2 while in_valid=1 with ACC ops -> result=0x03 stable, in_ready=0, acc unchanged; release -> ACC accepted on the same edge.
REQ-043 Assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, result=0, zero=1, acc=0 before the next edge.
